// File: rtl/cmd_frame_decoder.sv
// cmd_frame_decoder: parses framed RX commands into register-file/ALU strobes and
// pushes read data or ALU result bytes into the TX FIFO.
module cmd_frame_decoder #(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 4,
   parameter int FUN_WIDTH    = 4,
   parameter int RESP_TIMEOUT = 16
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [DATA_WIDTH-1:0]   RX_D,
   input  logic                    RX_D_VLD,
   input  logic [DATA_WIDTH-1:0]   RF_RdData,
   input  logic                    RF_RdData_VLD,
   input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
   input  logic                    ALU_OUT_VLD,
   input  logic                    FIFO_FULL,
   output logic                    RF_WrEn,
   output logic                    RF_RdEn,
   output logic [ADDR_WIDTH-1:0]   RF_Address,
   output logic [DATA_WIDTH-1:0]   RF_WrData,
   output logic                    ALU_EN,
   output logic [FUN_WIDTH-1:0]    ALU_FUN,
   output logic                    CLK_GATE_EN,
   output logic [DATA_WIDTH-1:0]   TX_D,
   output logic                    TX_D_VLD,
   output logic                    BUSY
);
   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_WR_ADDR  = 4'd1;
   localparam logic [3:0] S_WR_DATA  = 4'd2;
   localparam logic [3:0] S_RD_ADDR  = 4'd3;
   localparam logic [3:0] S_RD_WAIT  = 4'd4;
   localparam logic [3:0] S_TX_RD    = 4'd5;
   localparam logic [3:0] S_OPA      = 4'd6;
   localparam logic [3:0] S_OPB      = 4'd7;
   localparam logic [3:0] S_FUN      = 4'd8;
   localparam logic [3:0] S_ALU_WAIT = 4'd9;
   localparam logic [3:0] S_TX_LO    = 4'd10;
   localparam logic [3:0] S_TX_HI    = 4'd11;
   localparam logic [DATA_WIDTH-1:0] C_WR  = DATA_WIDTH'(8'hAA);
   localparam logic [DATA_WIDTH-1:0] C_RD  = DATA_WIDTH'(8'hBB);
   localparam logic [DATA_WIDTH-1:0] C_ALU = DATA_WIDTH'(8'hCC);
   localparam logic [DATA_WIDTH-1:0] C_FUN = DATA_WIDTH'(8'hDD);
   localparam int CW = $clog2(RESP_TIMEOUT) + 1;
   localparam logic [CW-1:0] C_TO = CW'(RESP_TIMEOUT - 1);

   logic [3:0]              r_state;
   logic [CW-1:0]           r_cnt;
   logic [ADDR_WIDTH-1:0]   r_wr_addr;
   logic [2*DATA_WIDTH-1:0] r_data;
   logic                    r_wr_en, r_rd_en, r_alu_en, r_gate, r_tx_vld, r_busy;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [DATA_WIDTH-1:0]   r_wr_data, r_tx_d;
   logic [FUN_WIDTH-1:0]    r_fun;
   logic [3:0]              w_next;
   logic                    w_tout, w_wait;

   assign w_tout = (r_cnt == C_TO);
   assign w_wait = (r_state == S_RD_WAIT) || (r_state == S_ALU_WAIT);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:     if (RX_D_VLD) w_next = (RX_D == C_WR)  ? S_WR_ADDR :
                                            (RX_D == C_RD)  ? S_RD_ADDR :
                                            (RX_D == C_ALU) ? S_OPA     :
                                            (RX_D == C_FUN) ? S_FUN     : S_IDLE;
         S_WR_ADDR:  if (RX_D_VLD) w_next = S_WR_DATA;
         S_WR_DATA:  if (RX_D_VLD) w_next = S_IDLE;
         S_RD_ADDR:  if (RX_D_VLD) w_next = S_RD_WAIT;
         S_RD_WAIT:  w_next = RF_RdData_VLD ? S_TX_RD : w_tout ? S_IDLE : S_RD_WAIT;
         S_TX_RD:    if (!FIFO_FULL) w_next = S_IDLE;
         S_OPA:      if (RX_D_VLD) w_next = S_OPB;
         S_OPB:      if (RX_D_VLD) w_next = S_FUN;
         S_FUN:      if (RX_D_VLD) w_next = S_ALU_WAIT;
         S_ALU_WAIT: w_next = ALU_OUT_VLD ? S_TX_LO : w_tout ? S_IDLE : S_ALU_WAIT;
         S_TX_LO:    if (!FIFO_FULL) w_next = S_TX_HI;
         S_TX_HI:    if (!FIFO_FULL) w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
   end

   // Strobes default low every cycle; data outputs hold until their strobe fires
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_wr_addr <= '0;
         r_data    <= '0;
         r_wr_en   <= 1'b0;
         r_rd_en   <= 1'b0;
         r_alu_en  <= 1'b0;
         r_gate    <= 1'b0;
         r_tx_vld  <= 1'b0;
         r_busy    <= 1'b0;
         r_addr    <= '0;
         r_wr_data <= '0;
         r_tx_d    <= '0;
         r_fun     <= '0;
      end else begin
         r_state  <= w_next;
         r_busy   <= (w_next != S_IDLE);
         r_gate   <= (w_next == S_FUN) || (w_next == S_ALU_WAIT);
         r_cnt    <= (w_wait && (w_next == r_state)) ? r_cnt + 1'b1 : '0;
         r_wr_en  <= 1'b0;
         r_rd_en  <= 1'b0;
         r_alu_en <= 1'b0;
         r_tx_vld <= 1'b0;
         case (r_state)
            S_WR_ADDR: if (RX_D_VLD) r_wr_addr <= RX_D[ADDR_WIDTH-1:0];
            S_WR_DATA: if (RX_D_VLD) begin
               r_wr_en   <= 1'b1;
               r_addr    <= r_wr_addr;
               r_wr_data <= RX_D;
            end
            S_RD_ADDR: if (RX_D_VLD) begin
               r_rd_en <= 1'b1;
               r_addr  <= RX_D[ADDR_WIDTH-1:0];
            end
            S_RD_WAIT: if (RF_RdData_VLD) r_data <= {{DATA_WIDTH{1'b0}}, RF_RdData};
            S_TX_RD: if (!FIFO_FULL) begin
               r_tx_vld <= 1'b1;
               r_tx_d   <= r_data[DATA_WIDTH-1:0];
            end
            S_OPA: if (RX_D_VLD) begin
               r_wr_en   <= 1'b1;
               r_addr    <= '0;
               r_wr_data <= RX_D;
            end
            S_OPB: if (RX_D_VLD) begin
               r_wr_en   <= 1'b1;
               r_addr    <= ADDR_WIDTH'(1);
               r_wr_data <= RX_D;
            end
            S_FUN: if (RX_D_VLD) begin
               r_alu_en <= 1'b1;
               r_fun    <= RX_D[FUN_WIDTH-1:0];
            end
            S_ALU_WAIT: if (ALU_OUT_VLD) r_data <= ALU_OUT;
            S_TX_LO: if (!FIFO_FULL) begin
               r_tx_vld <= 1'b1;
               r_tx_d   <= r_data[DATA_WIDTH-1:0];
            end
            S_TX_HI: if (!FIFO_FULL) begin
               r_tx_vld <= 1'b1;
               r_tx_d   <= r_data[2*DATA_WIDTH-1:DATA_WIDTH];
            end
            default: ;
         endcase
      end
   end

   assign RF_WrEn     = r_wr_en;
   assign RF_RdEn     = r_rd_en;
   assign RF_Address  = r_addr;
   assign RF_WrData   = r_wr_data;
   assign ALU_EN      = r_alu_en;
   assign ALU_FUN     = r_fun;
   assign CLK_GATE_EN = r_gate;
   assign TX_D        = r_tx_d;
   assign TX_D_VLD    = r_tx_vld;
   assign BUSY        = r_busy;
endmodule

// File: tb/tb_cmd_frame_decoder.sv
// tb_cmd_frame_decoder: directed frames checked every cycle against a frame-level
// model of the decoder, plus literal checks on key results.
module tb_cmd_frame_decoder;
   logic        CLK = 1'b0, RST = 1'b0;
   logic [7:0]  RX_D = '0, RF_RdData = '0;
   logic        RX_D_VLD = 1'b0, RF_RdData_VLD = 1'b0, ALU_OUT_VLD = 1'b0, FIFO_FULL = 1'b0;
   logic [15:0] ALU_OUT = '0;
   logic        RF_WrEn, RF_RdEn, ALU_EN, CLK_GATE_EN, TX_D_VLD, BUSY;
   logic [3:0]  RF_Address, ALU_FUN;
   logic [7:0]  RF_WrData, TX_D;

   cmd_frame_decoder dut (
      .CLK(CLK), .RST(RST), .RX_D(RX_D), .RX_D_VLD(RX_D_VLD),
      .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD),
      .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD), .FIFO_FULL(FIFO_FULL),
      .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address),
      .RF_WrData(RF_WrData), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
      .CLK_GATE_EN(CLK_GATE_EN), .TX_D(TX_D), .TX_D_VLD(TX_D_VLD), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   int n_chk = 0, n_fail = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: bytes of the frame collected so far, pending response kind, bytes owed to TX
   logic [7:0] fq[$];
   logic [7:0] txq[$];
   int         mode = 0, wcnt = 0;
   logic       e_wr, e_rd, e_alu, e_txv, e_gate, e_busy;
   logic [3:0] e_addr, e_fun;
   logic [7:0] e_wd, e_tx, b0, b1, b2, b3;
   int         wr_cnt = 0, rd_cnt = 0, alu_cnt = 0;
   logic [7:0] tx_log[$];

   task model_reset();
      fq.delete(); txq.delete(); mode = 0; wcnt = 0;
      {e_wr, e_rd, e_alu, e_txv, e_gate, e_busy} = '0;
      e_addr = '0; e_fun = '0; e_wd = '0; e_tx = '0;
   endtask

   task model_step();
      {e_wr, e_rd, e_alu, e_txv} = '0;
      if (txq.size() > 0) begin
         if (!FIFO_FULL) begin e_tx = txq.pop_front(); e_txv = 1'b1; end
      end else if (mode != 0) begin
         if (mode == 1 && RF_RdData_VLD) begin txq.push_back(RF_RdData); mode = 0; end
         else if (mode == 2 && ALU_OUT_VLD) begin
            txq.push_back(ALU_OUT[7:0]); txq.push_back(ALU_OUT[15:8]); mode = 0;
         end else if (wcnt == 15) mode = 0;
         else wcnt++;
      end else if (RX_D_VLD) begin
         fq.push_back(RX_D);
         b0 = fq[0];
         b1 = (fq.size() > 1) ? fq[1] : 8'h00;
         b2 = (fq.size() > 2) ? fq[2] : 8'h00;
         b3 = (fq.size() > 3) ? fq[3] : 8'h00;
         case (b0)
            8'hAA: if (fq.size() == 3) begin e_wr = 1; e_addr = b1[3:0]; e_wd = b2; fq.delete(); end
            8'hBB: if (fq.size() == 2) begin
               e_rd = 1; e_addr = b1[3:0]; fq.delete(); mode = 1; wcnt = 0;
            end
            8'hCC: begin
               if (fq.size() == 2) begin e_wr = 1; e_addr = 4'd0; e_wd = b1; end
               if (fq.size() == 3) begin e_wr = 1; e_addr = 4'd1; e_wd = b2; end
               if (fq.size() == 4) begin e_alu = 1; e_fun = b3[3:0]; fq.delete(); mode = 2; wcnt = 0; end
            end
            8'hDD: if (fq.size() == 2) begin e_alu = 1; e_fun = b1[3:0]; fq.delete(); mode = 2; wcnt = 0; end
            default: fq.delete();
         endcase
      end
      e_busy = (fq.size() > 0) || (mode != 0) || (txq.size() > 0);
      e_gate = (mode == 2) || (fq.size() == 3 && fq[0] == 8'hCC) || (fq.size() == 1 && fq[0] == 8'hDD);
   endtask

   always @(posedge CLK) begin
      if (!RST) model_reset();
      else model_step();
      #1;
      chk("RF_WrEn", RF_WrEn, e_wr);
      chk("RF_RdEn", RF_RdEn, e_rd);
      chk("RF_Address", RF_Address, e_addr);
      chk("RF_WrData", RF_WrData, e_wd);
      chk("ALU_EN", ALU_EN, e_alu);
      chk("ALU_FUN", ALU_FUN, e_fun);
      chk("CLK_GATE_EN", CLK_GATE_EN, e_gate);
      chk("TX_D", TX_D, e_tx);
      chk("TX_D_VLD", TX_D_VLD, e_txv);
      chk("BUSY", BUSY, e_busy);
      if (RST) begin
         if (RF_WrEn) wr_cnt++;
         if (RF_RdEn) rd_cnt++;
         if (ALU_EN) alu_cnt++;
         if (TX_D_VLD) tx_log.push_back(TX_D);
      end
   end

   task automatic send(input logic [7:0] b);
      @(negedge CLK); RX_D = b; RX_D_VLD = 1'b1;
      @(negedge CLK); RX_D_VLD = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic chk_all_zero(input string nm);
      chk(nm, {RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN, CLK_GATE_EN, TX_D, TX_D_VLD, BUSY}, 0);
   endtask

   initial begin
      idle(2);
      chk_all_zero("reset_outputs");
      RST = 1'b1;
      idle(1);
      // register write
      send(8'hAA); send(8'h05); send(8'h3C);
      idle(2);
      chk("wr_count", wr_cnt, 1);
      chk("wr_addr_lit", RF_Address, 4'h5);
      chk("wr_data_lit", RF_WrData, 8'h3C);
      chk("wr_busy_after", BUSY, 0);
      // register read, with a byte dropped during the wait
      send(8'hBB); send(8'h07);
      chk("rd_addr_lit", RF_Address, 4'h7);
      send(8'hAA);
      @(negedge CLK); RF_RdData = 8'h5A; RF_RdData_VLD = 1'b1;
      @(negedge CLK); RF_RdData_VLD = 1'b0;
      idle(3);
      chk("rd_count", rd_cnt, 1);
      chk("rd_tx_size", tx_log.size(), 1);
      if (tx_log.size() >= 1) chk("rd_tx_byte", tx_log[0], 8'h5A);
      chk("rd_busy_after", BUSY, 0);
      // ALU with operands
      send(8'hCC); send(8'h12); send(8'h34);
      chk("opa_opb_wr_count", wr_cnt, 3);
      chk("opb_addr_lit", RF_Address, 4'h1);
      chk("opb_data_lit", RF_WrData, 8'h34);
      send(8'h02);
      chk("alu_en_lit", ALU_EN, 1);
      chk("alu_fun_lit", ALU_FUN, 4'h2);
      chk("gate_lit", CLK_GATE_EN, 1);
      idle(1);
      ALU_OUT = 16'hBEEF; ALU_OUT_VLD = 1'b1;
      @(negedge CLK); ALU_OUT_VLD = 1'b0;
      idle(4);
      chk("alu_tx_size", tx_log.size(), 3);
      if (tx_log.size() >= 3) begin
         chk("alu_tx_lo", tx_log[1], 8'hEF);
         chk("alu_tx_hi", tx_log[2], 8'hBE);
      end
      chk("gate_after_alu", CLK_GATE_EN, 0);
      // ALU without operands, under TX backpressure
      send(8'hDD); send(8'h09);
      chk("alu_fun_nop_lit", ALU_FUN, 4'h9);
      idle(1);
      ALU_OUT = 16'hBEEF; ALU_OUT_VLD = 1'b1;
      @(negedge CLK); ALU_OUT_VLD = 1'b0; FIFO_FULL = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         chk("bp_no_push", TX_D_VLD, 0);
         chk("bp_tx_stable", TX_D, 8'hBE);
      end
      FIFO_FULL = 1'b0;
      @(negedge CLK);
      chk("bp_push_lo_vld", TX_D_VLD, 1);
      chk("bp_push_lo", TX_D, 8'hEF);
      @(negedge CLK);
      chk("bp_push_hi_vld", TX_D_VLD, 1);
      chk("bp_push_hi", TX_D, 8'hBE);
      idle(2);
      // read timeout: busy through 16 wait cycles, then idle without a push
      send(8'hBB); send(8'h01);
      idle(15);
      chk("to_busy_last_wait", BUSY, 1);
      idle(1);
      chk("to_busy_after", BUSY, 0);
      idle(2);
      chk("to_no_push", tx_log.size(), 5);
      // junk byte in IDLE
      send(8'h77);
      idle(2);
      chk("junk_wr", wr_cnt, 3);
      chk("junk_busy", BUSY, 0);
      // reset mid-frame
      send(8'hAA); send(8'h03);
      #2 RST = 1'b0;
      #1 chk_all_zero("midframe_reset");
      @(negedge CLK); RST = 1'b1;
      send(8'h99);
      idle(3);
      chk("post_reset_no_wr", wr_cnt, 3);
      chk("post_reset_busy", BUSY, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
